regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the 32 x 16-bit register file, which has two write ports. It accepts write requests from NUM_REQ producers (ALU, load unit, multiplier, ...) using valid/ready handshakes. Each cycle it grants up to two requests with round-robin fairness and drives them, registered, onto the register file's write ports 1 and 2. It guarantees that the two ports never target the same register in one cycle and that writes to r0 never consume a port.

---
 rtl/regfile_wb_arbiter_pkg.sv | 29 ++
 rtl/regfile_wb_arbiter_picker.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: register-file geometry, write-back request record and packing helper.
// Revision 1.0
`default_nettype none

package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 16;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [REG_ADDR_W+REG_DATA_W-1:0] pack_wb(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [REG_DATA_W-1:0] data
  );
    wb_req_t w_req;
    w_req.addr = addr;
    w_req.data = data;
    return w_req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_picker.sv
// wb_rr_picker: combinational find-first-set over a mask, scanning upward from a rotating pointer.
// Revision 1.0
`default_nettype none

module wb_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [PTR_W-1:0]   o_idx
);

  logic [PTR_W:0] w_j;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_j >= (PTR_W+1)'(NUM_REQ)) w_j = w_j - (PTR_W+1)'(NUM_REQ);
      if (!o_found && i_mask[w_j[PTR_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_j[PTR_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin two-port write-back arbiter for the register file.
// Optional macro WB_CONFLICT_CNT_EN adds oConflictCount. Revision 1.0
`default_nettype none

module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                        iClock,
  input  logic                        iReset_n,
  input  logic                        iHold,
  input  logic [NUM_REQ-1:0]          iReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0]   iReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0]   iReqData,
  output logic [NUM_REQ-1:0]          oReqReady,
  output logic                        oWritePort1,
  output logic [ADDR_W+DATA_W-1:0]    oRegWrite1,
  output logic                        oWritePort2,
  output logic [ADDR_W+DATA_W-1:0]    oRegWrite2
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]                 oConflictCount
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [ADDR_W-1:0]  w_addr [NUM_REQ];
  logic [DATA_W-1:0]  w_data [NUM_REQ];
  logic [NUM_REQ-1:0] w_zero, w_nz, w_mask2, w_ready;
  logic               w_found1, w_found2;
  logic [PTR_W-1:0]   w_idx1, w_idx2, w_rr_next;
  logic [ADDR_W-1:0]  w_addr1;
  logic [PTR_W-1:0]   r_rr;
  logic               r_wp1, r_wp2;
  logic [ADDR_W+DATA_W-1:0] r_word1, r_word2;

  assign w_addr1 = w_addr[w_idx1];

  // Port 2 candidates exclude the port-1 winner and anything aimed at the same register,
  // so same-register writes retire in rotational order on later cycles.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_addr[gi]  = iReqAddr[gi*ADDR_W +: ADDR_W];
    assign w_data[gi]  = iReqData[gi*DATA_W +: DATA_W];
    assign w_zero[gi]  = (w_addr[gi] == ADDR_W'(REG_ZERO));
    assign w_nz[gi]    = iReqValid[gi] & ~w_zero[gi] & ~iHold;
    assign w_mask2[gi] = w_nz[gi] & (w_idx1 != PTR_W'(gi)) & (w_addr[gi] != w_addr1);
    assign w_ready[gi] = iReqValid[gi] & ~iHold &
                         (w_zero[gi] | (w_found1 & (w_idx1 == PTR_W'(gi)))
                                     | (w_found2 & (w_idx2 == PTR_W'(gi))));
  end

  wb_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick1 (
    .i_mask (w_nz),
    .i_ptr  (r_rr),
    .o_found(w_found1),
    .o_idx  (w_idx1)
  );

  wb_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick2 (
    .i_mask (w_mask2),
    .i_ptr  (r_rr),
    .o_found(w_found2),
    .o_idx  (w_idx2)
  );

  always_comb begin
    w_rr_next = r_rr;
    if (w_found2)
      w_rr_next = (w_idx2 == PTR_W'(NUM_REQ-1)) ? '0 : w_idx2 + PTR_W'(1);
    else if (w_found1)
      w_rr_next = (w_idx1 == PTR_W'(NUM_REQ-1)) ? '0 : w_idx1 + PTR_W'(1);
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_rr    <= '0;
      r_wp1   <= 1'b0;
      r_wp2   <= 1'b0;
      r_word1 <= '0;
      r_word2 <= '0;
    end else begin
      r_rr  <= w_rr_next;
      r_wp1 <= w_found1;
      r_wp2 <= w_found2;
      if (w_found1) r_word1 <= {w_addr1, w_data[w_idx1]};
      if (w_found2) r_word2 <= {w_addr[w_idx2], w_data[w_idx2]};
    end
  end

  assign oReqReady   = w_ready & {NUM_REQ{iReset_n}};
  assign oWritePort1 = r_wp1;
  assign oWritePort2 = r_wp2;
  assign oRegWrite1  = r_word1;
  assign oRegWrite2  = r_word2;

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] r_conflict_cnt;
  logic        w_conflict;

  assign w_conflict = ~iHold & (|(iReqValid & ~w_ready));

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n)
      r_conflict_cnt <= '0;
    else if (w_conflict && (r_conflict_cnt != 16'hFFFF))
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign oConflictCount = r_conflict_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus hand-written reset and counter sequences.
// Revision 1.0
`default_nettype none

module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam logic [15:0] DA = 16'hAAAA;
  localparam logic [15:0] DB = 16'hBBBB;
  localparam logic [15:0] DC = 16'hCCCC;
  localparam logic [15:0] DD = 16'hDDDD;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [3:0]  valid;
  logic [19:0] addr;
  logic [63:0] data;
  logic [3:0]  ready;
  logic        wp1, wp2;
  logic [20:0] rw1, rw2;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] ccount;
`endif

  regfile_wb_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(16)) dut (
    .iClock     (clk),
    .iReset_n   (rst_n),
    .iHold      (hold),
    .iReqValid  (valid),
    .iReqAddr   (addr),
    .iReqData   (data),
    .oReqReady  (ready),
    .oWritePort1(wp1),
    .oRegWrite1 (rw1),
    .oWritePort2(wp2),
    .oRegWrite2 (rw2)
`ifdef WB_CONFLICT_CNT_EN
    ,
    .oConflictCount(ccount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    logic        hold;
    logic [3:0]  valid;
    logic [19:0] addrs;
    logic [3:0]  rdy;
    logic        e1;
    logic [20:0] w1;
    logic        e2;
    logic [20:0] w2;
  } vec_t;

  function automatic vec_t mk(input logic h, input logic [3:0] v,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] a3,
                              input logic [3:0] r,
                              input logic e1, input logic [20:0] w1,
                              input logic e2, input logic [20:0] w2);
    vec_t t;
    t.hold = h; t.valid = v; t.addrs = {a3, a2, a1, a0}; t.rdy = r;
    t.e1 = e1; t.w1 = w1; t.e2 = e2; t.w2 = w2;
    return t;
  endfunction

  vec_t vecs [15];

  initial begin
    vecs[0]  = mk(0, 4'b1111, 1, 2, 3, 4, 4'b0011, 1, pack_wb(1, DA), 1, pack_wb(2, DB));
    vecs[1]  = mk(0, 4'b1111, 1, 2, 3, 4, 4'b1100, 1, pack_wb(3, DC), 1, pack_wb(4, DD));
    vecs[2]  = mk(0, 4'b1111, 1, 2, 3, 4, 4'b0011, 1, pack_wb(1, DA), 1, pack_wb(2, DB));
    vecs[3]  = mk(1, 4'b1111, 1, 2, 3, 4, 4'b0000, 0, pack_wb(1, DA), 0, pack_wb(2, DB));
    vecs[4]  = mk(1, 4'b0001, 0, 2, 3, 4, 4'b0000, 0, pack_wb(1, DA), 0, pack_wb(2, DB));
    vecs[5]  = mk(0, 4'b1111, 1, 2, 3, 4, 4'b1100, 1, pack_wb(3, DC), 1, pack_wb(4, DD));
    vecs[6]  = mk(0, 4'b0000, 1, 2, 3, 4, 4'b0000, 0, pack_wb(3, DC), 0, pack_wb(4, DD));
    vecs[7]  = mk(0, 4'b0111, 7, 7, 9, 0, 4'b0101, 1, pack_wb(7, DA), 1, pack_wb(9, DC));
    vecs[8]  = mk(0, 4'b0010, 7, 7, 9, 0, 4'b0010, 1, pack_wb(7, DB), 0, pack_wb(9, DC));
    vecs[9]  = mk(0, 4'b1110, 1, 0, 3, 4, 4'b1110, 1, pack_wb(3, DC), 1, pack_wb(4, DD));
    vecs[10] = mk(0, 4'b0101, 0, 2, 0, 4, 4'b0101, 0, pack_wb(3, DC), 0, pack_wb(4, DD));
    vecs[11] = mk(0, 4'b1001, 5, 2, 3, 6, 4'b1001, 1, pack_wb(5, DA), 1, pack_wb(6, DD));
    vecs[12] = mk(0, 4'b1010, 1, 8, 3, 8, 4'b0010, 1, pack_wb(8, DB), 0, pack_wb(6, DD));
    vecs[13] = mk(0, 4'b1000, 1, 8, 3, 8, 4'b1000, 1, pack_wb(8, DD), 0, pack_wb(6, DD));
    vecs[14] = mk(0, 4'b1111, 1, 2, 3, 4, 4'b0011, 1, pack_wb(1, DA), 1, pack_wb(2, DB));

    data  = {DD, DC, DB, DA};
    hold  = 1'b0;
    valid = 4'b1111;
    addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    rst_n = 1'b0;

    // Reset held with every requester valid: nothing accepted, nothing written.
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_wp1", 32'(wp1), 32'h0);
    chk("rst_wp2", 32'(wp2), 32'h0);
    chk("rst_rw1", 32'(rw1), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_ready", 32'(ready), 32'h0);
    chk("rst_hold_wp1", 32'(wp1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (i != 0) @(negedge clk);
      hold  = vecs[i].hold;
      valid = vecs[i].valid;
      addr  = vecs[i].addrs;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wp1", i), 32'(wp1), 32'(vecs[i].e1));
      chk($sformatf("v%0d_wp2", i), 32'(wp2), 32'(vecs[i].e2));
      chk($sformatf("v%0d_rw1", i), 32'(rw1), 32'(vecs[i].w1));
      chk($sformatf("v%0d_rw2", i), 32'(rw2), 32'(vecs[i].w2));
    end

    // Reset mid-operation: pointer returns to 0 and buses clear.
    @(negedge clk);
    hold  = 1'b0;
    valid = 4'b1111;
    addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    chk("mid_ready_pre", 32'(ready), 32'hC);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_ready_rst", 32'(ready), 32'h0);
    chk("mid_wp1_rst", 32'(wp1), 32'h0);
    chk("mid_rw1_rst", 32'(rw1), 32'h0);
    chk("mid_rw2_rst", 32'(rw2), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_ready_post", 32'(ready), 32'h3);
    @(posedge clk);
    #1;
    chk("mid_wp1_post", 32'(wp1), 32'h1);
    chk("mid_rw1_post", 32'(rw1), 32'(pack_wb(1, DA)));
    chk("mid_rw2_post", 32'(rw2), 32'(pack_wb(2, DB)));

`ifdef WB_CONFLICT_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("cnt_reset", 32'(ccount), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'b0111;
    addr  = {5'd0, 5'd3, 5'd2, 5'd1};
    @(posedge clk);
    #1;
    chk("cnt_leftover", 32'(ccount), 32'h1);
    @(negedge clk);
    valid = 4'b0100;
    @(posedge clk);
    #1;
    chk("cnt_drained", 32'(ccount), 32'h1);
    @(negedge clk);
    valid = 4'b1111;
    addr  = {5'd7, 5'd7, 5'd7, 5'd7};
    repeat (65540) @(posedge clk);
    #1;
    chk("cnt_saturate", 32'(ccount), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
